// File: rtl/winner_sequencer.sv
// Inference-window controller for the SNN output layer: counts spikes per node over a
// programmable number of valid timesteps, then scans the counters serially for the argmax.
// Latency: winner_valid_o rises len + NUM_NODES + 1 cycles after start (no valid gaps).
// Backpressure: the result is held in DONE until winner_ready_i; start_i is only taken in IDLE.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   start_i / window_len_i                 - begin a window of window_len_i valid timesteps
//   spikes_valid_i / nodes_i               - one timestep of spikes, bit i = node i fired
//   busy_o                                 - high in ACCUM, SCAN and DONE
//   winner_valid_o / winner_ready_i        - result handshake
//   winner_idx_o, winner_count_o, tie_o    - registered result, held until the next result
//   abort_i                                - only with WINNER_SEQUENCER_ABORT_EN defined:
//                                            drops an ACCUM/SCAN window back to IDLE
module winner_sequencer #(
    parameter int NUM_NODES = 10,
    parameter int CNT_W     = 16,
    parameter int WIN_W     = 16,
    localparam int IDX_W    = $clog2(NUM_NODES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIN_W-1:0]     window_len_i,
    input  logic                 spikes_valid_i,
    input  logic [NUM_NODES-1:0] nodes_i,
`ifdef WINNER_SEQUENCER_ABORT_EN
    input  logic                 abort_i,
`endif
    output logic                 busy_o,
    output logic                 winner_valid_o,
    input  logic                 winner_ready_i,
    output logic [IDX_W-1:0]     winner_idx_o,
    output logic [CNT_W-1:0]     winner_count_o,
    output logic                 tie_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q [NUM_NODES];
    logic [WIN_W-1:0]     len_q;
    logic [WIN_W-1:0]     step_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     max_q, max_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 tie_q, tie_d;
    logic                 abort;
    logic                 start_ok;
    logic                 last_step;

`ifdef WINNER_SEQUENCER_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign start_ok  = start_i && (window_len_i != '0);
    assign last_step = spikes_valid_i && (step_q == len_q - WIN_W'(1));

    assign busy_o         = (state_q != IDLE);
    assign winner_valid_o = (state_q == DONE);

    // One comparison per SCAN cycle; pointer 0 seeds the running max.
    // Equal counts only raise tie, so the lowest index is kept.
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        tie_d = tie_q;
        if (ptr_q == '0) begin
            max_d = cnt_q[0];
            idx_d = '0;
            tie_d = 1'b0;
        end else if (cnt_q[ptr_q] > max_q) begin
            max_d = cnt_q[ptr_q];
            idx_d = ptr_q;
            tie_d = 1'b0;
        end else if (cnt_q[ptr_q] == max_q) begin
            tie_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = ACCUM;
            ACCUM:   if (abort) state_d = IDLE;
                     else if (last_step) state_d = SCAN;
            SCAN:    if (abort) state_d = IDLE;
                     else if (ptr_q == LAST_IDX) state_d = DONE;
            DONE:    if (winner_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_NODES; i++) cnt_q[i] <= '0;
            len_q          <= '0;
            step_q         <= '0;
            ptr_q          <= '0;
            max_q          <= '0;
            idx_q          <= '0;
            tie_q          <= 1'b0;
            winner_idx_o   <= '0;
            winner_count_o <= '0;
            tie_o          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        len_q  <= window_len_i;
                        step_q <= '0;
                        for (int i = 0; i < NUM_NODES; i++) cnt_q[i] <= '0;
                    end
                end
                ACCUM: begin
                    if (spikes_valid_i && !abort) begin
                        step_q <= step_q + WIN_W'(1);
                        for (int i = 0; i < NUM_NODES; i++) begin
                            // Saturate instead of wrapping.
                            if (nodes_i[i] && (cnt_q[i] != '1))
                                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
                SCAN: begin
                    if (abort) begin
                        ptr_q <= '0;
                    end else begin
                        max_q <= max_d;
                        idx_q <= idx_d;
                        tie_q <= tie_d;
                        if (ptr_q == LAST_IDX) begin
                            // Publish the result including the final comparison.
                            ptr_q          <= '0;
                            winner_idx_o   <= idx_d;
                            winner_count_o <= max_d;
                            tie_o          <= tie_d;
                        end else begin
                            ptr_q <= ptr_q + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_winner_sequencer.sv
module tb_winner_sequencer;

    localparam int NN    = 10;
    localparam int CW    = 4;
    localparam int WW    = 16;
    localparam int IW    = $clog2(NN);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [WW-1:0] window_len_i = '0;
    logic          spikes_valid_i = 1'b0;
    logic [NN-1:0] nodes_i = '0;
`ifdef WINNER_SEQUENCER_ABORT_EN
    logic          abort_i = 1'b0;
`endif
    logic          busy_o;
    logic          winner_valid_o;
    logic          winner_ready_i = 1'b0;
    logic [IW-1:0] winner_idx_o;
    logic [CW-1:0] winner_count_o;
    logic          tie_o;

    winner_sequencer #(.NUM_NODES(NN), .CNT_W(CW), .WIN_W(WW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .window_len_i   (window_len_i),
        .spikes_valid_i (spikes_valid_i),
        .nodes_i        (nodes_i),
`ifdef WINNER_SEQUENCER_ABORT_EN
        .abort_i        (abort_i),
`endif
        .busy_o         (busy_o),
        .winner_valid_o (winner_valid_o),
        .winner_ready_i (winner_ready_i),
        .winner_idx_o   (winner_idx_o),
        .winner_count_o (winner_count_o),
        .tie_o          (tie_o)
    );

    always #5 clk_i = ~clk_i;

    // Each valid timestep t drives always_m, plus early_m while t < early_n.
    // gap=1 inserts an invalid cycle (with all nodes firing) between valid ones.
    typedef struct {
        int            len;
        bit            gap;
        logic [NN-1:0] always_m;
        logic [NN-1:0] early_m;
        int            early_n;
        int            exp_idx;
        int            exp_cnt;
        bit            exp_tie;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one window up to the first negedge with winner_valid_o seen; leaves ready untouched.
    task automatic run_window(input vec_t v, input string tag);
        int edges;
        int acc_cycles;
        int t;
        @(negedge clk_i);
        start_i = 1'b1;
        window_len_i = WW'(v.len);
        @(posedge clk_i);
        edges = 1;
        @(negedge clk_i);
        start_i = 1'b0;
        check({tag, " busy_in_accum"}, busy_o, 1);
        acc_cycles = v.gap ? 2 * v.len - 1 : v.len;
        t = 0;
        for (int c = 0; c < acc_cycles; c++) begin
            if (c > 0) @(negedge clk_i);
            if (v.gap && (c % 2 == 1)) begin
                spikes_valid_i = 1'b0;
                nodes_i = '1;
            end else begin
                spikes_valid_i = 1'b1;
                nodes_i = v.always_m | ((t < v.early_n) ? v.early_m : '0);
                t++;
            end
            @(posedge clk_i);
            edges++;
        end
        @(negedge clk_i);
        spikes_valid_i = 1'b0;
        nodes_i = '1;
        while (!winner_valid_o && edges < 200) begin
            @(posedge clk_i);
            edges++;
            @(negedge clk_i);
        end
        nodes_i = '0;
        check({tag, " latency"}, edges, acc_cycles + NN + 1);
        check({tag, " idx"},   winner_idx_o,   v.exp_idx);
        check({tag, " count"}, winner_count_o, v.exp_cnt);
        check({tag, " tie"},   tie_o,          v.exp_tie);
    endtask

    task automatic handshake(input string tag);
        winner_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        winner_ready_i = 1'b0;
        check({tag, " valid_drop"}, winner_valid_o, 0);
        check({tag, " idle"},       busy_o,         0);
    endtask

    initial begin
        int seen;
        vecs[0] = '{4,  1'b0, 10'(1 << 3), 10'(1 << 7), 2, 3, 4,  1'b0};
        vecs[1] = '{3,  1'b0, 10'((1 << 2) | (1 << 5)), 10'd0, 0, 2, 3, 1'b1};
        vecs[2] = '{5,  1'b1, 10'(1 << 6), 10'(1 << 1), 3, 6, 5,  1'b0};
        vecs[3] = '{20, 1'b0, 10'(1 << 0), 10'd0, 0, 0, 15, 1'b0};
        vecs[4] = '{1,  1'b0, 10'd0,       10'd0, 0, 0, 0,  1'b1};
        vecs[5] = '{2,  1'b0, 10'(1 << 9), 10'd0, 0, 9, 2,  1'b0};
        vecs[6] = '{6,  1'b0, 10'(1 << 4), 10'(1 << 1), 2, 4, 6, 1'b0};

        #12;
        check("reset busy",  busy_o,         0);
        check("reset valid", winner_valid_o, 0);
        check("reset idx",   winner_idx_o,   0);
        check("reset count", winner_count_o, 0);
        check("reset tie",   tie_o,          0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_window(vecs[i], $sformatf("vec%0d", i));
            handshake($sformatf("vec%0d", i));
        end

        // Result held in DONE while ready is low; start pulses are ignored.
        run_window(vecs[0], "hold");
        for (int c = 0; c < 6; c++) begin
            start_i = (c % 2 == 0);
            window_len_i = 3;
            @(posedge clk_i);
            @(negedge clk_i);
            check("hold valid", winner_valid_o, 1);
            check("hold idx",   winner_idx_o,   3);
            check("hold count", winner_count_o, 4);
            check("hold tie",   tie_o,          0);
        end
        // Start coinciding with the handshake is dropped.
        start_i = 1'b1;
        winner_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        winner_ready_i = 1'b0;
        check("hs_start valid", winner_valid_o, 0);
        check("hs_start busy",  busy_o,         0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("hs_start dropped", busy_o, 0);
        // Zero-length start is ignored.
        start_i = 1'b1;
        window_len_i = 0;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        check("len0 busy", busy_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("len0 still idle", busy_o, 0);

        // Ready held high in advance: valid lasts exactly one cycle.
        winner_ready_i = 1'b1;
        run_window(vecs[1], "early_rdy");
        @(posedge clk_i);
        @(negedge clk_i);
        winner_ready_i = 1'b0;
        check("early_rdy one_cycle", winner_valid_o, 0);
        check("early_rdy idle",      busy_o,         0);

        // Asynchronous reset mid-ACCUM clears everything at once.
        start_i = 1'b1;
        window_len_i = 10;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        spikes_valid_i = 1'b1;
        nodes_i = '1;
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst busy",  busy_o,         0);
        check("arst valid", winner_valid_o, 0);
        check("arst count", winner_count_o, 0);
        check("arst tie",   tie_o,          0);
        spikes_valid_i = 1'b0;
        nodes_i = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        run_window(vecs[4], "post_rst");
        handshake("post_rst");

`ifdef WINNER_SEQUENCER_ABORT_EN
        // Abort during SCAN returns to IDLE with no result.
        @(negedge clk_i);
        start_i = 1'b1;
        window_len_i = 2;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        spikes_valid_i = 1'b1;
        nodes_i = 10'd1;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        spikes_valid_i = 1'b0;
        nodes_i = '0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort in_scan", busy_o, 1);
        abort_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        abort_i = 1'b0;
        check("abort idle", busy_o, 0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (winner_valid_o) seen++;
        end
        check("abort no_valid", seen, 0);
`else
        seen = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/winner_sequencer.md
Name: winner_sequencer

Overview:
Inference-window controller for the SNN output layer. It sequences one classification:
- Accepts a start command.
- Accumulates per-node spike counts over a programmable number of valid timesteps.
- Scans the counters serially, one node per cycle, to find the argmax.
- Presents the winning index and count on a valid/ready handshake.

It sits after the output neuron layer and replaces free-running spike counting with a bounded, restartable window.

Parameters:
NUM_NODES, 10, number of output neurons; must be >= 2
CNT_W, 16, width of each per-node spike counter
WIN_W, 16, width of the window-length field
IDX_W (localparam), $clog2(NUM_NODES), winner index width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
start_i  in  1  start a new window; sampled only in IDLE
window_len_i  in  WIN_W  number of valid timesteps in the window; sampled with start_i
spikes_valid_i  in  1  nodes_i carries one timestep
nodes_i  in  NUM_NODES  spike vector, bit i = node i fired
busy_o  out  1  high in ACCUM, SCAN and DONE
winner_valid_o  out  1  result available
winner_ready_i  in  1  consumer accepts result
winner_idx_o  out  IDX_W  winning node index
winner_count_o  out  CNT_W  spike count of the winner
tie_o  out  1  another node equalled the winning count

Behaviour:
- One clock, clk_i. rst_i is asynchronous, active-high.
- Reset clears all state: state=IDLE, all counters 0, step counter 0, scan pointer 0, and every output 0.
- Reset mid-window or mid-scan discards all partial results.
- IDLE:
  - start_i=1 and window_len_i!=0: latch window_len_i, clear all counters and the step counter, go to ACCUM next cycle.
  - start_i=1 with window_len_i==0: ignored; stay in IDLE.
- ACCUM:
  - Each cycle with spikes_valid_i=1: counter[i] += nodes_i[i] for every i, and the step counter increments.
  - Counters saturate at 2^CNT_W-1; no wrap.
  - Cycles with spikes_valid_i=0 change nothing.
  - On the valid cycle where step == len-1, that timestep is still counted and the next state is SCAN. Exactly len valid timesteps are counted.
  - start_i is ignored.
- SCAN:
  - The first SCAN cycle loads max=counter[0], idx=0, tie=0.
  - Each following cycle examines node k, for k=1..NUM_NODES-1:
    - counter[k] > max: max=counter[k], idx=k, tie=0.
    - counter[k] == max: tie=1, idx unchanged, so the lowest index wins.
  - SCAN lasts exactly NUM_NODES cycles, then goes to DONE.
  - nodes_i is ignored during SCAN.
- DONE:
  - winner_valid_o=1; winner_idx_o, winner_count_o and tie_o are registered and stable until the handshake.
  - winner_valid_o & winner_ready_i moves to IDLE next cycle, deasserting winner_valid_o.
  - winner_ready_i may be held high in advance; the handshake then completes in the first DONE cycle.
  - start_i is ignored; a start in the same cycle as the handshake is dropped.
- Result outputs hold their last values in IDLE; only winner_valid_o qualifies them.
- Latency: with no valid-gaps, winner_valid_o rises len + NUM_NODES + 1 cycles after the start_i edge.
- All-zero counts give idx=0, count=0, tie=1.

Optional Feature:
Macro: WINNER_SEQUENCER_ABORT_EN.
- Defined:
  - Adds input abort_i (1 bit).
  - abort_i=1 in ACCUM or SCAN returns to IDLE next cycle with no winner_valid_o pulse; counters are left as-is.
  - abort_i in DONE is ignored.
  - Abort has priority over the ACCUM->SCAN transition in the same cycle.
- Not defined: the port does not exist and windows always run to completion.

Test Plan:
- NUM_NODES=10, len=4; node 3 spikes on all 4 valid cycles, node 7 on 2, others none -> idx=3, count=4, tie=0; valid at cycle 15.
- len=3; nodes 2 and 5 each spike 3 times -> idx=2, count=3, tie=1.
- len=5; spikes_valid_i toggles 1/0 -> only the 5 valid cycles counted; SCAN entered after the 5th valid cycle.
- CNT_W=4, len=20; node 0 spikes every cycle -> count saturates at 15, idx=0; then a second start with len=1 and no spikes -> idx=0, count=0, tie=1 (counters cleared).
- winner_ready_i held low for 6 cycles in DONE with start_i pulsed -> outputs stable, start ignored; ready=1 -> IDLE; start with len=0 -> stays IDLE, busy_o=0.
- rst_i asserted mid-ACCUM, asynchronous to the clock edge -> busy_o and winner_valid_o go 0 immediately; with the macro defined, abort_i in SCAN -> IDLE, no valid pulse.
